sweep_ctrl: RTL
===============

Name: sweep_ctrl

Overview:
- Frequency-sweep sequencer for the DDS function generator, clocked on Fg_clk.
- Steps the coefficient-table address from a start to a stop value in programmable increments.
- At each step, issues a frequency-change handshake to the oscillator and holds each frequency for a programmable dwell time.
- Sits between the control front end (rotary/button) and Table_coef/Oscillator; its address/FreqChng outputs are muxed with the rotary path at top level.

Parameters:
- ADDR_W, 11, table address width.
- DWELL_W, 24, dwell counter width (Fg_clk cycles).
- SETTLE, 2, cycles the address is held stable before FreqChng (covers table read latency).
- RDY_TIMEOUT, 1023, max cycles to wait for Ready before flagging error.

Ports:
- Fg_clk  in  1  function-generator clock.
- Resetn  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse, begin sweep (ignored unless IDLE/DONE/ERR).
- Abort  in  1  one-cycle pulse, abandon sweep.
- Continuous  in  1  1 = wrap to StartAddr after StopAddr; 0 = single sweep. Sampled at Start.
- StartAddr  in  ADDR_W  first table address. Sampled at Start.
- StopAddr  in  ADDR_W  last table address. Sampled at Start.
- StepSize  in  ADDR_W  address increment, 0 treated as 1. Sampled at Start.
- Dwell  in  DWELL_W  cycles to hold each frequency after Ready. Sampled at Start.
- Ready  in  1  oscillator has reloaded coefficients.
- address  out  ADDR_W  table address to Table_coef.
- FreqChng  out  1  one-cycle pulse to oscillator.
- Busy  out  1  sweep in progress.
- Done  out  1  single sweep completed; sticky until next Start.
- Err  out  1  Ready timeout; sticky until next Start.

Behaviour:
- Reset: all outputs 0, state IDLE, all sampled registers 0.
- State machine: IDLE, SETUP, CHNG, WAIT_RDY, DWELL, STEP, DONE, ERR.
- IDLE/DONE/ERR, on Start:
  - capture config; dir = (StopAddr >= StartAddr) ? up : down;
  - address <= StartAddr; clear Done/Err; go to SETUP.
  - Busy=1 in every state except IDLE/DONE/ERR.
- SETUP: count SETTLE cycles with address stable, then go to CHNG.
- CHNG: FreqChng=1 for exactly this cycle; clear timeout counter; go to WAIT_RDY.
- WAIT_RDY:
  - Ready sampled starting the cycle after the FreqChng pulse.
  - Ready=1 -> load dwell counter with Dwell, go to DWELL.
  - Counter reaching RDY_TIMEOUT -> ERR, Err=1.
- DWELL: decrement the counter each cycle; at 0, go to STEP. Dwell=0 means zero extra cycles.
- STEP (one cycle):
  - If address == StopAddr: Continuous=1 -> address <= StartAddr, go to SETUP; otherwise go to DONE, Done=1.
  - Otherwise, step in the sweep direction:
    - up: next = address+StepSize; if next > StopAddr or the carry overflows ADDR_W, next = StopAddr (clamp, never skip the endpoint);
    - down: next = address-StepSize; if next < StopAddr or it borrows, next = StopAddr.
  - Store next in address, go to SETUP.
- Arithmetic: compute at ADDR_W+1 bits to detect carry/borrow.
- StartAddr == StopAddr: one CHNG, then DONE (or repeated CHNG on the same address if Continuous).
- Abort in any non-idle state: next cycle -> IDLE, Busy=0, address held, FreqChng forced 0, Done/Err unchanged. Abort in IDLE is ignored.
- Abort and Start in the same cycle: Abort wins.
- Start while Busy: ignored.
- Asynchronous reset mid-sweep: immediate return to the reset values.
- Latency: Start to first FreqChng = 1 + SETTLE cycles. Per-step period = SETTLE + 1 + ready_wait + Dwell + 1 cycles.

Test Plan:
1. Up sweep: Start, StartAddr=10, StopAddr=20, Step=5, Dwell=3, Ready returned 2 cycles after each FreqChng -> address sequence 10,15,20; 3 FreqChng pulses; Done=1; each pulse 1 cycle, each preceded by 2 stable-address cycles.
2. Clamp and down sweep:
   - Start=20, Stop=3, Step=8 -> addresses 20,12,4,3; Done=1.
   - Start=2040, Stop=2047, Step=5 -> 2040,2045,2047 with no wrap.
3. Continuous wrap: Start=0, Stop=4, Step=2, Continuous=1 -> 0,2,4,0,2,...; Done stays 0; Abort during DWELL -> Busy=0 next cycle, address holds its last value, no further FreqChng.
4. Timeout: Ready held 0 after the first FreqChng -> Err=1 and Busy=0 exactly RDY_TIMEOUT cycles later; a following Start clears Err and resumes normally.
5. Corner cases:
   - Step=0 behaves as Step=1.
   - StartAddr=StopAddr=7 -> single FreqChng, then Done.
   - Start pulsed while Busy -> no effect on the sequence.
   - Abort and Start together in IDLE -> stays IDLE.
6. Reset: Resetn deasserted asynchronously mid-WAIT_RDY -> all outputs 0 immediately, without a clock edge; after release, a normal sweep completes.

Source files
------------

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: walks the coefficient-table address from StartAddr to
// StopAddr, pulsing FreqChng per step and dwelling after each oscillator Ready.
module sweep_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int DWELL_W     = 24,
  parameter int SETTLE      = 2,     // must be >= 1
  parameter int RDY_TIMEOUT = 1023   // must be >= 2
) (
  input  logic               Fg_clk,
  input  logic               Resetn,
  input  logic               Start,
  input  logic               Abort,
  input  logic               Continuous,
  input  logic [ADDR_W-1:0]  StartAddr,
  input  logic [ADDR_W-1:0]  StopAddr,
  input  logic [ADDR_W-1:0]  StepSize,
  input  logic [DWELL_W-1:0] Dwell,
  input  logic               Ready,
  output logic [ADDR_W-1:0]  address,
  output logic               FreqChng,
  output logic               Busy,
  output logic               Done,
  output logic               Err
);

  localparam int TMO_W = $clog2(RDY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CHNG, S_WAIT_RDY, S_DWELL, S_STEP, S_DONE, S_ERR
  } state_t;

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_addr, r_start, r_stop, r_step;
  logic [DWELL_W-1:0] r_dwell, r_cnt;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_cont, r_up, r_done, r_err;
  logic               w_busy, w_fc, w_abort, w_at_stop;
  logic [ADDR_W:0]    w_sum, w_dif;
  logic [ADDR_W-1:0]  w_step_addr;

  // Extra MSB catches carry/borrow so the endpoint is clamped rather than wrapped past.
  assign w_sum     = {1'b0, r_addr} + {1'b0, r_step};
  assign w_dif     = {1'b0, r_addr} - {1'b0, r_step};
  assign w_at_stop = (r_addr == r_stop);

  always_comb begin
    w_step_addr = r_stop;
    if (r_up) begin
      if (!w_sum[ADDR_W] && (w_sum[ADDR_W-1:0] <= r_stop)) w_step_addr = w_sum[ADDR_W-1:0];
    end else begin
      if (!w_dif[ADDR_W] && (w_dif[ADDR_W-1:0] >= r_stop)) w_step_addr = w_dif[ADDR_W-1:0];
    end
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b1;
    w_fc    = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        w_busy = 1'b0;
        if (Start && !Abort) w_next = S_SETUP;
      end
      S_SETUP:    if (r_cnt == DWELL_W'(SETTLE - 1)) w_next = S_CHNG;
      S_CHNG: begin
        w_fc   = 1'b1;
        w_next = S_WAIT_RDY;
      end
      // Timeout lands Err exactly RDY_TIMEOUT cycles after the FreqChng cycle.
      S_WAIT_RDY: begin
        if (Ready)                                    w_next = (r_dwell == '0) ? S_STEP : S_DWELL;
        else if (r_tmo == TMO_W'(RDY_TIMEOUT - 2))    w_next = S_ERR;
      end
      S_DWELL:    if (r_cnt == DWELL_W'(1)) w_next = S_STEP;
      S_STEP:     w_next = (w_at_stop && !r_cont) ? S_DONE : S_SETUP;
      default:    w_next = S_IDLE;
    endcase
    if (w_busy && Abort) begin
      w_abort = 1'b1;
      w_next  = S_IDLE;
    end
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      r_addr  <= '0;
      r_start <= '0;
      r_stop  <= '0;
      r_step  <= '0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_cont  <= 1'b0;
      r_up    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (!w_abort) begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (Start && !Abort) begin
            r_start <= StartAddr;
            r_stop  <= StopAddr;
            r_step  <= (StepSize == '0) ? ADDR_W'(1) : StepSize;
            r_dwell <= Dwell;
            r_cont  <= Continuous;
            r_up    <= (StopAddr >= StartAddr);
            r_addr  <= StartAddr;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_SETUP:    r_cnt <= r_cnt + DWELL_W'(1);
        S_CHNG:     r_tmo <= '0;
        S_WAIT_RDY: begin
          r_tmo <= r_tmo + TMO_W'(1);
          if (Ready) r_cnt <= r_dwell;
          else if (w_next == S_ERR) r_err <= 1'b1;
        end
        S_DWELL:    r_cnt <= r_cnt - DWELL_W'(1);
        S_STEP: begin
          r_cnt <= '0;
          if (!w_at_stop)  r_addr <= w_step_addr;
          else if (r_cont) r_addr <= r_start;
          else             r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign address  = r_addr;
  assign FreqChng = w_fc;
  assign Busy     = w_busy;
  assign Done     = r_done;
  assign Err      = r_err;

endmodule
